// File: rtl/input_conditioner.sv
// N-channel raw input conditioner: 2-flop synchroniser, polarity normalisation,
// tick-qualified counter debounce and registered rise/fall pulses.
module input_conditioner #(
  parameter int unsigned            CHANNELS        = 4,
  parameter int unsigned            DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0]    ACTIVE_LOW_MASK = '0,
  parameter int unsigned            CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic                clk,
  input  logic                Reset_n,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic                sample_tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] norm_c;
  logic [CNT_W-1:0]    cnt      [CHANNELS];
  logic [CNT_W-1:0]    cnt_next [CHANNELS];
  logic [CHANNELS-1:0] level_next;
  logic [CHANNELS-1:0] rise_next;
  logic [CHANNELS-1:0] fall_next;

  assign norm_c = sync2 ^ ACTIVE_LOW_MASK;

  // Per-channel debounce decision; a disagreeing input must survive a full tick count.
  always_comb begin
    level_next = level;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_next[i] = cnt[i];
      if (norm_c[i] == level[i]) begin
        cnt_next[i] = '0;
      end else if (sample_tick) begin
        if (cnt[i] == CNT_LAST) begin
          cnt_next[i]   = '0;
          level_next[i] = norm_c[i];
          rise_next[i]  = norm_c[i];
          fall_next[i]  = ~norm_c[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // State and output registers; reset discards any in-progress count.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      sync1    <= ACTIVE_LOW_MASK;
      sync2    <= ACTIVE_LOW_MASK;
      level    <= '0;
      rise     <= '0;
      fall     <= '0;
      any_rise <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= raw_in;
      sync2    <= sync1;
      level    <= level_next;
      rise     <= rise_next;
      fall     <= fall_next;
      any_rise <= |rise_next;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised N-channel conditioner for raw board inputs (KEY pushbuttons, SW slide switches) ahead of the CPU's Btns/Din/Sample/Reset pins.
- Per channel: 2-flop synchroniser, per-channel polarity normalisation, counter-based debounce, registered rise/fall pulses.
- Successor to the ad-hoc direct wiring of KEY/SW into MyComputer; one instance per input group.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 16, consecutive qualifying ticks a changed input must hold before the output level flips (>=1).
- ACTIVE_LOW_MASK, 0, CHANNELS-bit mask; bit i=1 means raw_in[i] is active-low (KEY) and is inverted before debounce.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  synchronous active-low reset
- raw_in  input  CHANNELS  asynchronous raw inputs from pins
- sample_tick  input  1  debounce qualifier; tie to 1 for per-clock debounce, or drive with a prescaler strobe
- level  output  CHANNELS  debounced, normalised (1 = active) level
- rise  output  CHANNELS  1-cycle pulse when level[i] goes 0->1
- fall  output  CHANNELS  1-cycle pulse when level[i] goes 1->0
- any_rise  output  1  OR of rise[], same cycle

Behaviour:
- Reset (Reset_n=0 at a clk edge): sync1/sync2 <= ACTIVE_LOW_MASK (inactive raw value), counters <= 0, level <= 0, rise <= 0, fall <= 0, any_rise <= 0. Reset has priority over every other event, mid-debounce included; an in-progress count is discarded.
- Synchroniser: sync1 <= raw_in; sync2 <= sync1. norm[i] = sync2[i] XOR ACTIVE_LOW_MASK[i].
- Per channel, each edge out of reset:
  - norm==level: cnt <= 0 (clear is not gated by sample_tick).
  - norm!=level and sample_tick=0: cnt holds.
  - norm!=level, sample_tick=1, cnt<DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - norm!=level, sample_tick=1, cnt==DEBOUNCE_CYCLES-1: level <= norm, cnt <= 0, rise/fall asserted per direction.
- rise/fall default 0 every cycle; each is high exactly one cycle, on the same edge level flips. rise[i] and fall[i] are never high together.
- Latency with sample_tick=1: raw change first sampled at edge e0; level flips at edge e0+DEBOUNCE_CYCLES+1. DEBOUNCE_CYCLES=1 gives a flip at e0+2.
- Glitch rejection: any return of norm to level before the terminal tick clears cnt; no level change, no pulse.
- Channels are fully independent; simultaneous flips on several channels produce simultaneous pulses.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Outputs are registered only; no combinational path from raw_in to any output.

Test Plan:
- CHANNELS=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW_MASK=4'b0011 for all cases; sample_tick=1 unless stated.
- Reset: hold Reset_n=0 three cycles with raw_in=4'b0011 -> level=0, rise=fall=any_rise=0. Release -> level stays 0 indefinitely.
- Active-high press: raw_in[2] 0->1 before edge e0 and held -> level[2]=1 and rise[2]=any_rise=1 exactly at edge e0+5, rise[2]=0 at e0+6. Release to 0 -> fall[2] one-cycle pulse 5 edges after first sampling.
- Active-low KEY: raw_in[0] 1->0 held -> level[0]=1 with rise[0] pulse at e0+5. raw_in[0] back to 1 -> fall[0] pulse, level[0]=0.
- Glitch: raw_in[3] high for 3 cycles then low -> level[3], rise[3], fall[3] stay 0 throughout.
- Tick gating: sample_tick high every 3rd cycle, raw_in[2] held high -> level[2] flips on the 4th tick edge after sync2 change, not before. Counter holds between ticks.
- Reset mid-debounce: raw_in[2] high, assert Reset_n=0 at e0+3 for one cycle -> no pulse. Level[2] rises 5 edges after reset release (full count restarts).
